// File: rtl/alu16_sequencer_pkg.sv
// Shared definitions for the 16-bit ALU sequencer: flag positions, ALU op
// and size codes, command and state encodings, and the final-flag rule.
package alu16_sequencer_pkg;

  localparam int F_Z = 3;
  localparam int F_N = 2;
  localparam int F_H = 1;
  localparam int F_C = 0;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_ADC   = 5'd1;
  localparam logic [4:0] ALU_SUB   = 5'd2;
  localparam logic [4:0] ALU_SBC   = 5'd3;
  localparam logic [4:0] ALU_PASS0 = 5'd16;

  localparam logic ALU_SIZE_8  = 1'b0;
  localparam logic ALU_SIZE_16 = 1'b1;

  typedef enum logic [1:0] {
    CMD_ADD16 = 2'd0,
    CMD_INC16 = 2'd1,
    CMD_DEC16 = 2'd2,
    CMD_ADDSP = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // ADD16 keeps Z and reports the high-byte H/C; ADDSP clears Z/N and reports
  // the low-byte H/C; INC16/DEC16 leave the flags untouched.
  function automatic logic [3:0] final_flags(input cmd_t cmd, input logic [3:0] fl,
                                             input logic lo_h, input logic lo_c,
                                             input logic hi_h, input logic hi_c);
    logic [3:0] f;
    f = fl;
    case (cmd)
      CMD_ADD16: begin
        f[F_N] = 1'b0;
        f[F_H] = hi_h;
        f[F_C] = hi_c;
      end
      CMD_ADDSP: begin
        f      = 4'b0000;
        f[F_H] = lo_h;
        f[F_C] = lo_c;
      end
      default: f = fl;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu16_sequencer.sv
// Drives the shared 8-bit ALU for two consecutive byte operations (low byte,
// then high byte with carry/borrow) to implement ADD HL,rr / INC rr / DEC rr /
// ADD SP,e, then presents the 16-bit result and ZNHC flags.
module alu16_sequencer
  import alu16_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_in,
  input  logic [1:0]  cmd_in,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic [3:0]  flags_in,
  output logic        busy_out,
  output logic        own_alu_out,
  output logic        done_out,
  output logic [15:0] result_out,
  output logic [3:0]  flags_out,
  output logic [7:0]  alu_data0_out,
  output logic [7:0]  alu_data1_out,
  output logic [4:0]  alu_op_out,
  output logic [3:0]  alu_flags_out,
  output logic        alu_size_out,
  input  logic [7:0]  alu_data_in,
  input  logic [3:0]  alu_flags_in
);

  state_t      state, state_next;
  logic        accept;
  cmd_t        cmd_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [3:0]  fl_q;
  logic [7:0]  res_lo;
  logic        fl_lo_h;
  logic        fl_lo_c;

  // Z and N from the ALU are never consumed: the final flag rules only use H/C.
  logic unused_alu_flags;
  assign unused_alu_flags = ^{alu_flags_in[F_Z], alu_flags_in[F_N]};

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next state and ALU drive, derived only from the state and latched operands.
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    busy_out      = 1'b0;
    alu_data0_out = 8'h00;
    alu_data1_out = 8'h00;
    alu_op_out    = ALU_PASS0;
    alu_flags_out = 4'b0000;
    alu_size_out  = ALU_SIZE_8;
    case (state)
      S_IDLE: begin
        if (start_in) begin
          state_next = S_LOW;
          accept     = 1'b1;
        end
      end
      S_LOW: begin
        state_next    = S_HIGH;
        busy_out      = 1'b1;
        alu_data1_out = a_q[7:0];
        alu_flags_out = fl_q;
        alu_size_out  = ALU_SIZE_8;
        case (cmd_q)
          CMD_INC16: begin
            alu_op_out    = ALU_ADD;
            alu_data0_out = 8'h01;
          end
          CMD_DEC16: begin
            alu_op_out    = ALU_SUB;
            alu_data0_out = 8'h01;
          end
          default: begin
            alu_op_out    = ALU_ADD;
            alu_data0_out = b_q[7:0];
          end
        endcase
      end
      S_HIGH: begin
        state_next    = S_DONE;
        busy_out      = 1'b1;
        alu_data1_out = a_q[15:8];
        alu_flags_out = fl_q;
        alu_size_out  = ALU_SIZE_16;
        case (cmd_q)
          CMD_ADD16: begin
            alu_op_out         = ALU_ADC;
            alu_data0_out      = b_q[15:8];
            alu_flags_out[F_C] = fl_lo_c;
          end
          CMD_ADDSP: begin
            // Sign-extend the 8-bit displacement into the high byte.
            alu_op_out         = ALU_ADC;
            alu_data0_out      = {8{b_q[7]}};
            alu_flags_out[F_C] = fl_lo_c;
          end
          CMD_INC16: begin
            // Carry into the high byte is known from the operand alone; the
            // incoming Z/N/H/C must survive, so the low-byte ALU flags are not used.
            alu_op_out         = ALU_ADC;
            alu_data0_out      = 8'h00;
            alu_flags_out[F_C] = (a_q[7:0] == 8'hFF);
          end
          default: begin
            alu_op_out         = ALU_SBC;
            alu_data0_out      = 8'h00;
            alu_flags_out[F_C] = (a_q[7:0] == 8'h00);
          end
        endcase
      end
      S_DONE: begin
        if (start_in) begin
          state_next = S_LOW;
          accept     = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign own_alu_out = busy_out;
  assign done_out    = (state == S_DONE);

  // Operand latches, low-byte capture, and final result/flags on leaving S_HIGH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q      <= CMD_ADD16;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      fl_q       <= 4'b0000;
      res_lo     <= 8'h00;
      fl_lo_h    <= 1'b0;
      fl_lo_c    <= 1'b0;
      result_out <= 16'h0000;
      flags_out  <= 4'b0000;
    end else begin
      if (accept) begin
        cmd_q <= cmd_t'(cmd_in);
        a_q   <= a_in;
        b_q   <= b_in;
        fl_q  <= flags_in;
      end
      if (state == S_LOW) begin
        res_lo  <= alu_data_in;
        fl_lo_h <= alu_flags_in[F_H];
        fl_lo_c <= alu_flags_in[F_C];
      end
      if (state == S_HIGH) begin
        result_out <= {alu_data_in, res_lo};
        flags_out  <= final_flags(cmd_q, fl_q, fl_lo_h, fl_lo_c,
                                  alu_flags_in[F_H], alu_flags_in[F_C]);
      end
    end
  end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Directed bench for alu16_sequencer with a behavioural 8-bit ALU beside it.
module tb_alu16_sequencer;
  import alu16_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_in;
  logic [1:0]  cmd_in;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  flags_in;
  logic        busy_out;
  logic        own_alu_out;
  logic        done_out;
  logic [15:0] result_out;
  logic [3:0]  flags_out;
  logic [7:0]  alu_data0;
  logic [7:0]  alu_data1;
  logic [4:0]  alu_op;
  logic [3:0]  alu_flags_out;
  logic        alu_size;
  logic [7:0]  alu_res;
  logic [3:0]  alu_fl;

  int checks = 0;
  int errors = 0;

  alu16_sequencer dut (
    .clock         (clk),
    .reset_n       (reset_n),
    .start_in      (start_in),
    .cmd_in        (cmd_in),
    .a_in          (a_in),
    .b_in          (b_in),
    .flags_in      (flags_in),
    .busy_out      (busy_out),
    .own_alu_out   (own_alu_out),
    .done_out      (done_out),
    .result_out    (result_out),
    .flags_out     (flags_out),
    .alu_data0_out (alu_data0),
    .alu_data1_out (alu_data1),
    .alu_op_out    (alu_op),
    .alu_flags_out (alu_flags_out),
    .alu_size_out  (alu_size),
    .alu_data_in   (alu_res),
    .alu_flags_in  (alu_fl)
  );

  always #5 clk = ~clk;

  // Reference 8-bit ALU: result = data1 op data0 (op carry), ZNHC flags.
  always_comb begin
    int d0, d1, ci, r;
    d0      = int'(alu_data0);
    d1      = int'(alu_data1);
    ci      = int'(alu_flags_out[F_C]);
    r       = 0;
    alu_res = alu_data0;
    alu_fl  = alu_flags_out;
    if (alu_op == ALU_ADD || alu_op == ALU_ADC) begin
      if (alu_op == ALU_ADD) ci = 0;
      r           = d1 + d0 + ci;
      alu_res     = 8'(r);
      alu_fl[F_Z] = ((r & 255) == 0);
      alu_fl[F_N] = 1'b0;
      alu_fl[F_H] = (((d1 & 15) + (d0 & 15) + ci) > 15);
      alu_fl[F_C] = (r > 255);
    end else if (alu_op == ALU_SUB || alu_op == ALU_SBC) begin
      if (alu_op == ALU_SUB) ci = 0;
      r           = d1 - d0 - ci;
      alu_res     = 8'(r);
      alu_fl[F_Z] = ((r & 255) == 0);
      alu_fl[F_N] = 1'b1;
      alu_fl[F_H] = (((d1 & 15) - (d0 & 15) - ci) < 0);
      alu_fl[F_C] = (r < 0);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation with inputs scrambled after acceptance.
  task automatic do_op(input string tag, input logic [1:0] cmd, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] fl,
                       input logic [15:0] er, input logic [3:0] ef,
                       input logic [4:0] lo_op, input logic [7:0] lo_d0);
    @(negedge clk);
    cmd_in = cmd; a_in = a; b_in = b; flags_in = fl; start_in = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_lo_busy"}, 16'(busy_out), 16'd1);
    chk({tag, "_lo_own"}, 16'(own_alu_out), 16'd1);
    chk({tag, "_lo_op"}, 16'(alu_op), 16'(lo_op));
    chk({tag, "_lo_d0"}, 16'(alu_data0), 16'(lo_d0));
    chk({tag, "_lo_d1"}, 16'(alu_data1), 16'(a[7:0]));
    chk({tag, "_lo_size"}, 16'(alu_size), 16'(ALU_SIZE_8));
    @(negedge clk);
    start_in = 1'b0; cmd_in = ~cmd; a_in = ~a; b_in = ~b; flags_in = ~fl;
    @(posedge clk); #1;
    chk({tag, "_hi_done"}, 16'(done_out), 16'd0);
    chk({tag, "_hi_size"}, 16'(alu_size), 16'(ALU_SIZE_16));
    chk({tag, "_hi_d1"}, 16'(alu_data1), 16'(a[15:8]));
    @(posedge clk); #1;
    chk({tag, "_done"}, 16'(done_out), 16'd1);
    chk({tag, "_busy_off"}, 16'(busy_out), 16'd0);
    chk({tag, "_result"}, result_out, er);
    chk({tag, "_flags"}, 16'(flags_out), 16'(ef));
    chk({tag, "_drive_idle"}, 16'(alu_op), 16'(ALU_PASS0));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 16'(done_out), 16'd0);
    chk({tag, "_held"}, result_out, er);
  endtask

  initial begin
    reset_n = 1'b0; start_in = 1'b0; cmd_in = 2'd0;
    a_in = 16'h0; b_in = 16'h0; flags_in = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 16'(busy_out), 16'd0);
    chk("rst_done", 16'(done_out), 16'd0);
    chk("rst_result", result_out, 16'h0000);
    chk("rst_flags", 16'(flags_out), 16'h0);
    chk("rst_op", 16'(alu_op), 16'(ALU_PASS0));
    chk("rst_d0", 16'(alu_data0), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;

    do_op("add16_h",    2'd0, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010, ALU_ADD, 8'h01);
    do_op("add16_wrap", 2'd0, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011, ALU_ADD, 8'h01);
    do_op("inc16",      2'd1, 16'h00FF, 16'h1234, 4'b1010, 16'h0100, 4'b1010, ALU_ADD, 8'h01);
    do_op("inc16_wrap", 2'd1, 16'hFFFF, 16'h0000, 4'b0100, 16'h0000, 4'b0100, ALU_ADD, 8'h01);
    do_op("dec16_wrap", 2'd2, 16'h0000, 16'h0000, 4'b0101, 16'hFFFF, 4'b0101, ALU_SUB, 8'h01);
    do_op("addsp_pos",  2'd3, 16'hFFF8, 16'h0008, 4'b1100, 16'h0000, 4'b0011, ALU_ADD, 8'h08);
    do_op("addsp_neg",  2'd3, 16'h1000, 16'h00FE, 4'b1111, 16'h0FFE, 4'b0000, ALU_ADD, 8'hFE);

    // start_in held high for six edges: ops accepted at edges 1 and 4 only.
    @(negedge clk);
    cmd_in = 2'd0; a_in = 16'h1234; b_in = 16'h1111; flags_in = 4'b0000; start_in = 1'b1;
    @(posedge clk); #1;
    chk("b2b_e1_busy", 16'(busy_out), 16'd1);
    @(negedge clk);
    a_in = 16'h0100; b_in = 16'h0001; flags_in = 4'b1000;
    @(posedge clk); #1;
    chk("b2b_e2_done", 16'(done_out), 16'd0);
    @(posedge clk); #1;
    chk("b2b_e3_done", 16'(done_out), 16'd1);
    chk("b2b_e3_result", result_out, 16'h2345);
    chk("b2b_e3_flags", 16'(flags_out), 16'h0);
    @(posedge clk); #1;
    chk("b2b_e4_busy", 16'(busy_out), 16'd1);
    chk("b2b_e4_done", 16'(done_out), 16'd0);
    chk("b2b_e4_held", result_out, 16'h2345);
    @(negedge clk);
    a_in = 16'hAAAA; b_in = 16'h5555; flags_in = 4'b0111;
    @(posedge clk); #1;
    chk("b2b_e5_busy", 16'(busy_out), 16'd1);
    @(posedge clk); #1;
    chk("b2b_e6_done", 16'(done_out), 16'd1);
    chk("b2b_e6_result", result_out, 16'h0101);
    chk("b2b_e6_flags", 16'(flags_out), 16'b1000);
    @(negedge clk);
    start_in = 1'b0;
    @(posedge clk); #1;
    chk("b2b_e7_done", 16'(done_out), 16'd0);
    chk("b2b_e7_busy", 16'(busy_out), 16'd0);

    // Asynchronous reset while in S_HIGH.
    @(negedge clk);
    cmd_in = 2'd0; a_in = 16'h5678; b_in = 16'h1111; flags_in = 4'b1111; start_in = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start_in = 1'b0;
    @(posedge clk); #1;
    chk("mrst_pre_busy", 16'(busy_out), 16'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mrst_busy", 16'(busy_out), 16'd0);
    chk("mrst_own", 16'(own_alu_out), 16'd0);
    chk("mrst_done", 16'(done_out), 16'd0);
    chk("mrst_op", 16'(alu_op), 16'(ALU_PASS0));
    chk("mrst_d1", 16'(alu_data1), 16'h0);
    chk("mrst_aflags", 16'(alu_flags_out), 16'h0);
    chk("mrst_size", 16'(alu_size), 16'd0);
    chk("mrst_result", result_out, 16'h0000);
    chk("mrst_flags", 16'(flags_out), 16'h0);
    @(posedge clk); #1;
    chk("mrst_no_done", 16'(done_out), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_op("post_rst", 2'd0, 16'h1234, 16'h0001, 4'b0110, 16'h1235, 4'b0000, ALU_ADD, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
